// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared constants, detection mode and fill-width helper for seq_detect_multi
package seq_detect_pkg;

  localparam int PAT_W_MAX   = 16;
  localparam int NUM_PAT_MAX = 8;

  typedef enum logic {
    MODE_NON_OVERLAP = 1'b0,
    MODE_OVERLAP     = 1'b1
  } det_mode_e;

  // Fill must be able to hold the value PAT_W itself (saturation point).
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_slot.sv
// rtl/seq_match_slot.sv - one pattern slot: compare, fill tracking, hit register, hit counter when SEQ_DETECT_CNT_EN is defined
module seq_match_slot
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             din_vld_i,
  input  logic             en_i,
  input  det_mode_e        mode_i,
  input  logic [PAT_W-1:0] window_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             hit_d_o,
  output logic             hit_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int                FILL_W   = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [FILL_W-1:0] fill_q, fill_d;
  logic              hit_q, hit_d;
  logic              match;

  always_comb begin
    match  = din_vld_i & en_i & (window_i == pattern_i) & (fill_q >= FILL_ARM);
    fill_d = fill_q;
    hit_d  = 1'b0;
    if (clr_i) begin
      fill_d = '0;
    end else if (din_vld_i) begin
      hit_d = match;
      // Non-overlapping: the slot must see a full fresh pattern before it may fire again.
      if (match && mode_i == MODE_NON_OVERLAP) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      hit_q  <= hit_d;
    end
  end

  assign hit_d_o = hit_d;
  assign hit_o   = hit_q;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (hit_d && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/seq_detect_multi.sv
// rtl/seq_detect_multi.sv - multi-pattern serial detector top; per-slot hit counters enabled by SEQ_DETECT_CNT_EN
module seq_detect_multi
  import seq_detect_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_vld,
  input  logic                     din,
  input  logic                     clr,
  input  logic                     overlap,
  input  logic [NUM_PAT-1:0]       pat_en,
  input  logic [NUM_PAT*PAT_W-1:0] pat_cfg,
  output logic [NUM_PAT-1:0]       hit,
  output logic                     hit_any,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
);

  logic [PAT_W-2:0]   hist_q, hist_d;
  logic [PAT_W-1:0]   window;
  logic [NUM_PAT-1:0] hit_d;
  logic               hit_any_q, hit_any_d;
  det_mode_e          mode;

  assign window = {hist_q, din};
  assign mode   = det_mode_e'(overlap);

  always_comb begin
    hist_d    = hist_q;
    hit_any_d = 1'b0;
    if (clr) begin
      hist_d = '0;
    end else begin
      hit_any_d = |hit_d;
      if (din_vld) begin
        hist_d = window[PAT_W-2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      hit_any_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      hit_any_q <= hit_any_d;
    end
  end

  assign hit_any = hit_any_q;

  for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
    seq_match_slot #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr),
      .din_vld_i (din_vld),
      .en_i      (pat_en[i]),
      .mode_i    (mode),
      .window_i  (window),
      .pattern_i (pat_cfg[i*PAT_W +: PAT_W]),
      .hit_d_o   (hit_d[i]),
      .hit_o     (hit[i]),
      .cnt_o     (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_seq_detect_multi.sv
// tb/tb_seq_detect_multi.sv - scoreboard bench for seq_detect_multi against a bit-stream reference model
module tb_seq_detect_multi;

  localparam int PAT_W   = 4;
  localparam int NUM_PAT = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int PMASK   = (1 << PAT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     din_vld = 1'b0;
  logic                     din = 1'b0;
  logic                     clr = 1'b0;
  logic                     overlap = 1'b1;
  logic [NUM_PAT-1:0]       pat_en = '1;
  logic [NUM_PAT*PAT_W-1:0] pat_cfg = {4'b0110, 4'b1101};
  logic [NUM_PAT-1:0]       hit;
  logic                     hit_any;
  logic [NUM_PAT*CNT_W-1:0] hit_cnt;

  seq_detect_multi #(
    .PAT_W   (PAT_W),
    .NUM_PAT (NUM_PAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din_vld (din_vld),
    .din     (din),
    .clr     (clr),
    .overlap (overlap),
    .pat_en  (pat_en),
    .pat_cfg (pat_cfg),
    .hit     (hit),
    .hit_any (hit_any),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_PAT-1:0]       hit;
    logic                     any;
    logic [NUM_PAT*CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: last bits since clear as an integer, per-slot bits since slot restart, hit totals.
  int unsigned hist_m = 0;
  int          since_m[NUM_PAT];
  int          cnt_m[NUM_PAT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    hist_m = 0;
    for (int i = 0; i < NUM_PAT; i++) begin
      since_m[i] = 0;
      cnt_m[i]   = 0;
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic c);
    exp_t        e;
    int unsigned win;
    int unsigned pat;
    @(negedge clk);
    din_vld = v;
    din     = d;
    clr     = c;
    e.hit = '0;
    e.cnt = '0;
    if (c) begin
      model_reset();
    end else if (v) begin
      win = ((hist_m << 1) | 32'(d)) & PMASK;
      for (int i = 0; i < NUM_PAT; i++) begin
        pat = 32'(pat_cfg[i*PAT_W +: PAT_W]);
        if (pat_en[i] && win == pat && since_m[i] + 1 >= PAT_W) begin
          e.hit[i] = 1'b1;
          if (cnt_m[i] < CNT_MAX) cnt_m[i]++;
          since_m[i] = overlap ? since_m[i] + 1 : 0;
        end else begin
          since_m[i]++;
        end
      end
      hist_m = win;
    end
`ifdef SEQ_DETECT_CNT_EN
    for (int i = 0; i < NUM_PAT; i++) e.cnt[i*CNT_W +: CNT_W] = CNT_W'(cnt_m[i]);
`endif
    e.any = |e.hit;
    exp_q.push_back(e);
  endtask

  task automatic feed(input int n, input logic [15:0] bits, input bit gaps);
    logic [15:0] b;
    b = bits;
    for (int k = n - 1; k >= 0; k--) begin
      drive(1'b1, b[k], 1'b0);
      if (gaps) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic reconf(input logic ov, input logic [NUM_PAT-1:0] en, input logic [NUM_PAT*PAT_W-1:0] cfg);
    @(posedge clk);
    #3;
    overlap = ov;
    pat_en  = en;
    pat_cfg = cfg;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_hit", 64'(hit), 64'd0);
    chk("async_rst_any", 64'(hit_any), 64'd0);
    chk("async_rst_cnt", 64'(hit_cnt), 64'd0);
    @(negedge clk);
    din_vld = 1'b0;
    clr     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hit", 64'(hit), 64'(e.hit));
        chk("hit_any", 64'(hit_any), 64'(e.any));
        chk("hit_cnt", 64'(hit_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    #1;
    chk("reset_hit", 64'(hit), 64'd0);
    chk("reset_any", 64'(hit_any), 64'd0);
    chk("reset_cnt", 64'(hit_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    feed(3, 16'b101, 1'b0);
    feed(4, 16'b1101, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);

    for (int ov = 1; ov >= 0; ov--) begin
      for (int g = 0; g < 2; g++) begin
        reconf(ov[0], '1, {4'b0110, 4'b1101});
        feed(7, 16'b1101101, g[0]);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
      end
    end

    reconf(1'b1, '1, {4'b0110, 4'b1101});
    feed(3, 16'b110, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    feed(1, 16'b1, 1'b0);
    feed(3, 16'b101, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);

    reconf(1'b1, '1, {4'b0110, 4'b1111});
    feed(10, 16'h3ff, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    reconf(1'b1, '1, {4'b0110, 4'b1101});
    feed(3, 16'b110, 1'b0);
    async_reset();
    feed(1, 16'b1, 1'b0);
    feed(4, 16'b1101, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        reconf(1'($urandom_range(0, 1)), NUM_PAT'($urandom_range(0, (1 << NUM_PAT) - 1)),
               NUM_PAT*PAT_W'($urandom));
      end
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
    end
    drive(1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
